// File: rtl/windowed_lut_integrator_if.sv
// windowed_lut_integrator_if: sample-in / window-result-out bundle.
// The master drives samples and the slave returns windowed sums and phase status.
`default_nettype none

interface windowed_lut_integrator_if #(
    parameter int IDX_W = 4,
    parameter int ACC_W = 13,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic [IDX_W-1:0] x;
    logic             out_valid;
    logic [ACC_W-1:0] y;
    logic             overflow;
    logic             phase;
    logic [CNT_W-1:0] cnt;

    modport master (
        output in_valid, x,
        input  out_valid, y, overflow, phase, cnt
    );

    modport slave (
        input  in_valid, x,
        output out_valid, y, overflow, phase, cnt
    );
endinterface

`default_nettype wire

// File: rtl/windowed_lut_integrator.sv
// windowed_lut_integrator: sums lut[x] = STEP*x over WIN_LEN accepted samples, then skips SKIP_LEN.
// Overflow is sticky per window; SAT_EN selects clamp or wrap.
`default_nettype none

module windowed_lut_integrator #(
    parameter int IDX_W    = 4,
    parameter int STEP     = 25,
    parameter int VAL_W    = 9,
    parameter int ACC_W    = 13,
    parameter int WIN_LEN  = 4,
    parameter int SKIP_LEN = 4,
    parameter int SAT_EN   = 0,
    parameter int CNT_W    = $clog2(((WIN_LEN > SKIP_LEN) ? WIN_LEN : SKIP_LEN) + 1)
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  clear_i,
    windowed_lut_integrator_if.slave   bus
);
    localparam logic [0:0]       S_ACCUM   = 1'b0;
    localparam logic [0:0]       S_SKIP    = 1'b1;
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_LEN > 0) ? SKIP_LEN - 1 : 0);

    logic [VAL_W-1:0] lut [2**IDX_W];

    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_lut
        assign lut[i] = VAL_W'(STEP * i);
    end

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wov_q, wov_d;
    logic [ACC_W-1:0] y_q, y_d;
    logic             ov_q, ov_d;
    logic             vld_q, vld_d;

    logic [VAL_W-1:0] lut_val;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic             accept;
    logic             win_done;
    logic             skip_done;

    assign lut_val   = lut[bus.x];
    assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - VAL_W){1'b0}}, lut_val};
    assign carry     = sum[ACC_W];
    assign accept    = bus.in_valid & ~clear_i;
    assign win_done  = accept && (state_q == S_ACCUM) && (cnt_q == WIN_LAST);
    assign skip_done = accept && (state_q == S_SKIP) && (cnt_q == SKIP_LAST);

    // A clamped accumulator keeps carrying on every nonzero add, so it stays at all-ones.
    always_comb begin
        acc_add = sum[ACC_W-1:0];
        if (carry && (SAT_EN != 0)) begin
            acc_add = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_ACCUM;
        end else if (win_done && (SKIP_LEN > 0)) begin
            state_d = S_SKIP;
        end else if (skip_done) begin
            state_d = S_ACCUM;
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        wov_d = wov_q;
        y_d   = y_q;
        ov_d  = ov_q;
        vld_d = 1'b0;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
            wov_d = 1'b0;
        end else if (accept) begin
            if (state_q == S_ACCUM) begin
                if (win_done) begin
                    y_d   = acc_add;
                    ov_d  = wov_q | carry;
                    vld_d = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                    wov_d = 1'b0;
                end else begin
                    acc_d = acc_add;
                    wov_d = wov_q | carry;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = skip_done ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            wov_q <= 1'b0;
            y_q   <= '0;
            ov_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            wov_q <= wov_d;
            y_q   <= y_d;
            ov_q  <= ov_d;
            vld_q <= vld_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.y         = y_q;
    assign bus.overflow  = ov_q;
    assign bus.phase     = state_q[0];
    assign bus.cnt       = cnt_q;

endmodule

`default_nettype wire
